// File: rtl/dmem_arbiter.sv
// Two-port arbiter sequencing CPU (port 0) and loader (port 1) accesses to a shared data RAM.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_id;
  logic              r_we;
  logic              r_oor;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_busy;

  logic              w_any_req;
  logic              w_pick1;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_oor;

  assign w_any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  // Last granted port; reset to 1 so port 0 wins the first tie.
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_grant <= w_pick1;
    end
  end

  assign w_pick1 = req1 & (~req0 | ~r_last_grant);
`else
  assign w_pick1 = req1 & ~req0;
`endif

  assign w_we    = w_pick1 ? we1    : we0;
  assign w_addr  = w_pick1 ? addr1  : addr0;
  assign w_wdata = w_pick1 ? wdata1 : wdata0;
  assign w_oor   = 32'(w_addr) >= DEPTH;

  // Sequencer: IDLE latches the winner, ACCESS drives the RAM, DONE reports completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_id        <= w_pick1;
            r_we        <= w_we;
            r_oor       <= w_oor;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_ram_addr  <= w_addr;
            r_ram_wdata <= w_wdata;
            r_ram_we    <= w_we & ~w_oor;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_DONE;
          // Out-of-range loads return zero rather than whatever the RAM decodes.
          if (!r_we) begin
            if (r_id) r_rdata1 <= r_oor ? '0 : ram_rdata;
            else      r_rdata0 <= r_oor ? '0 : ram_rdata;
          end
          r_done0 <= ~r_id;
          r_done1 <= r_id;
          r_err0  <= ~r_id & r_oor;
          r_err1  <= r_id & r_oor;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: a full-depth instance plus a DEPTH=200 instance.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          preload;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, done0, err0, gnt1, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we, busy;

  logic          x_req0, x_we0, x_req1, x_we1;
  logic [AW-1:0] x_addr0, x_addr1;
  logic [DW-1:0] x_wdata0, x_wdata1;
  logic          x_gnt0, x_done0, x_err0, x_gnt1, x_done1, x_err1;
  logic [DW-1:0] x_rdata0, x_rdata1;
  logic [AW-1:0] x_ram_addr;
  logic [DW-1:0] x_ram_wdata, x_ram_rdata;
  logic          x_ram_we, x_busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1), .err1(err1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(200)) u_oor (
    .clk(clk), .rst_n(rst_n),
    .req0(x_req0), .we0(x_we0), .addr0(x_addr0), .wdata0(x_wdata0),
    .gnt0(x_gnt0), .done0(x_done0), .rdata0(x_rdata0), .err0(x_err0),
    .req1(x_req1), .we1(x_we1), .addr1(x_addr1), .wdata1(x_wdata1),
    .gnt1(x_gnt1), .done1(x_done1), .rdata1(x_rdata1), .err1(x_err1),
    .ram_addr(x_ram_addr), .ram_wdata(x_ram_wdata), .ram_we(x_ram_we),
    .ram_rdata(x_ram_rdata), .busy(x_busy)
  );

  // Behavioural RAMs, combinational read
  logic [DW-1:0] mem   [0:255];
  logic [DW-1:0] x_mem [0:255];
  assign ram_rdata   = mem[ram_addr];
  assign x_ram_rdata = x_mem[x_ram_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[8'(i)] <= '0;
      mem[8'h03] <= 16'h0004;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) x_mem[8'(i)] <= '0;
      x_mem[8'h10] <= 16'hAAAA;
      x_mem[8'hF0] <= 16'h1234;
    end else if (x_ram_we) begin
      x_mem[x_ram_addr] <= x_ram_wdata;
    end
  end

  typedef struct packed {
    logic          port;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_rd  [2];
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, run protocol checks, retire completions against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("gnt_exclusive", 32'(gnt0 & gnt1), 0);
    chk("done_exclusive", 32'(done0 & done1), 0);
    chk("ram_we_only_in_access", 32'(ram_we & ~(gnt0 | gnt1)), 0);
    chk("err_without_done", 32'((err0 & ~done0) | (err1 & ~done1)), 0);
    chk("oor_ram_we_low", 32'(x_ram_we), 0);
    if (!(gnt0 | gnt1)) chk("ram_bus_idle_zero", 32'({ram_addr, ram_wdata}), 0);
    if (done0 | done1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done0 | done1), 0);
      end else begin
        e = sbq.pop_front();
        chk("done_port", 32'(done1), 32'(e.port));
        chk("done_err", 32'(e.port ? err1 : err0), 32'(e.err));
        chk("done_rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.rdata));
      end
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic push_exp(input bit p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    if (we) ref_mem[a] = d;
    else    exp_rd[p] = ref_mem[a];
    e.port  = p;
    e.err   = 1'b0;
    e.rdata = exp_rd[p];
    sbq.push_back(e);
  endtask

  // Single access from IDLE; ends after the IDLE cycle that follows DONE.
  task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n;
    int we_cyc;
    bit seen;
    drive(p, 1'b1, we, a, d);
    push_exp(p, we, a, d);
    n = 0; we_cyc = 0; seen = 1'b0;
    while (!seen && n < 8) begin
      tick();
      n++;
      if (ram_we) begin
        we_cyc++;
        chk("ram_we_addr", 32'(ram_addr), 32'(a));
        chk("ram_we_wdata", 32'(ram_wdata), 32'(d));
      end
      seen = p ? gnt1 : gnt0;
    end
    chk("gnt_seen", 32'(seen), 1);
    chk("gnt_latency", 32'(n), 1);
    chk("ram_we_cycles", 32'(we_cyc), we ? 1 : 0);
    drive(p, 1'b0, we, a, d);
    tick();
    chk("done_latency", 32'(p ? done1 : done0), 1);
    chk("busy_in_done", 32'(busy), 1);
    tick();
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic x_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit exp_err, input logic [DW-1:0] exp_rdata);
    x_req0 = 1'b1; x_we0 = we; x_addr0 = a; x_wdata0 = d;
    tick();
    chk("x_gnt0", 32'(x_gnt0), 1);
    x_req0 = 1'b0;
    tick();
    chk("x_done0", 32'(x_done0), 1);
    chk("x_err0", 32'(x_err0), 32'(exp_err));
    chk("x_rdata0", 32'(x_rdata0), 32'(exp_rdata));
    tick();
  endtask

  initial begin
    int  last_t, cnt, t, g;
    bit  exp_g [4];

    rst_n = 1'b0; preload = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    x_req0 = 1'b0; x_we0 = 1'b0; x_addr0 = '0; x_wdata0 = '0;
    x_req1 = 1'b0; x_we1 = 1'b0; x_addr1 = '0; x_wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_mem[8'h03] = 16'h0004;
    exp_rd[0] = '0; exp_rd[1] = '0;

    repeat (3) tick();
    rst_n = 1'b1; preload = 1'b0;
    tick();
    chk("reset_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, ram_we, busy}), 0);
    chk("reset_rdata", 32'({rdata0, rdata1}), 0);
    chk("reset_ram_bus", 32'({ram_addr, ram_wdata}), 0);

    // Port 0 load from 0x03
    access(0, 0, 8'h03, '0);

    // Port 1 load, port 1 store, then port 0 reads the stored word back
    access(1, 0, 8'h03, '0);
    access(1, 1, 8'h20, 16'hBEEF);
    chk("rdata1_after_store", 32'(rdata1), 32'h0004);
    access(0, 0, 8'h20, '0);
    chk("rdata1_unchanged", 32'(rdata1), 32'h0004);

    // Top address is in range with full depth
    access(0, 1, 8'hFF, 16'h1357);
    access(0, 0, 8'hFF, '0);

    // Back-to-back port 0 loads with req0 held
    drive(0, 1, 0, 8'h03, '0);
    repeat (3) push_exp(0, 0, 8'h03, '0);
    last_t = -1; cnt = 0; t = 0;
    while (cnt < 3 && t < 20) begin
      tick();
      t++;
      if (done0) begin
        if (last_t >= 0) chk("done0_period", 32'(t - last_t), 3);
        last_t = t;
        cnt++;
        if (cnt == 3) drive(0, 0, 0, 8'h03, '0);
      end
    end
    chk("b2b_done_count", 32'(cnt), 3);
    tick();

    // DEPTH=200 instance: in-range load, then OOR store and load
    x_access(0, 8'h10, '0, 0, 16'hAAAA);
    x_access(1, 8'hF0, 16'h5555, 1, 16'hAAAA);
    x_access(0, 8'hF0, '0, 1, 16'h0000);

    // Reset during ACCESS of a port 1 store
    drive(1, 1, 1, 8'h40, 16'h7777);
    tick();
    chk("rst_pre_gnt1", 32'(gnt1), 1);
    drive(1, 0, 1, 8'h40, 16'h7777);
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_no_done1", 32'({done1, err1}), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
    rst_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    tick();
    chk("rst_after_no_done", 32'({done0, done1}), 0);

    // Simultaneous requests held for four grants
`ifdef DMEM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
    drive(0, 1, 0, 8'h03, '0);
    drive(1, 1, 0, 8'h20, '0);
    for (int k = 0; k < 4; k++) begin
      if (exp_g[k]) push_exp(1, 0, 8'h20, '0);
      else          push_exp(0, 0, 8'h03, '0);
    end
    g = 0; t = 0;
    while (g < 4 && t < 30) begin
      tick();
      t++;
      if (gnt0 | gnt1) begin
        chk("tie_grant", 32'(gnt1), 32'(exp_g[g]));
        g++;
        if (g == 4) begin
          drive(0, 0, 0, 8'h03, '0);
          drive(1, 0, 0, 8'h20, '0);
        end
      end
    end
    chk("tie_grant_count", 32'(g), 4);
    repeat (2) tick();
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the 256 x 16 data RAM between two requesters.
- Port 0 is the CPU load/store stage; port 1 is the init/DMA loader.
- Owns the RAM's address, write-data and write-enable inputs. Serializes accesses through a 3-state FSM with request/grant/done handshakes.
- Registers read data per port. Flags out-of-range addresses.

Parameters:
- ADDR_W, 8, address width of requester and RAM ports.
- DATA_W, 16, data word width.
- DEPTH, 256, number of valid RAM words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0: 1 = store, 0 = load
- addr0  in  ADDR_W  port 0 word address
- wdata0  in  DATA_W  port 0 store data
- gnt0  out  1  port 0 request accepted (1-cycle pulse)
- done0  out  1  port 0 access complete (1-cycle pulse)
- rdata0  out  DATA_W  port 0 load data, valid with done0 and held after
- err0  out  1  port 0 out-of-range access (pulses with done0)
- req1, we1, addr1, wdata1, gnt1, done1, rdata1, err1: same as port 0, for port 1
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable (1 = write, 0 = read)
- ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clk and rst_n as above; synchronous, active-low.
  - State = IDLE; all outputs 0, including rdata0/1 = 0.
  - RR pointer favours port 0.
  - Reset mid-access: in-flight access aborted. No done/err pulse. ram_we low from the next cycle.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay.
  - Any req: arbitrate (see Optional Feature).
  - Latch the winner's id, we, addr, wdata; go to ACCESS.
  - The winner's gnt pulses high during the ACCESS cycle.
- ACCESS (exactly 1 cycle):
  - ram_addr = latched addr; ram_wdata = latched wdata.
  - ram_we = latched we AND in-range.
  - On the clock edge:
    - Read, in range: rdata<id> <= ram_rdata.
    - Read, out of range: rdata<id> <= 0.
  - Go to DONE.
- DONE (1 cycle):
  - done<id> = 1.
  - err<id> = 1 if out of range.
  - ram_we = 0.
  - Go to IDLE.
- Latency:
  - Request seen in IDLE at edge N: gnt in cycle N+1, done in cycle N+2.
  - Load data is visible on rdata in cycle N+2.
  - Peak throughput: 1 access per 3 cycles.
- Requester rules:
  - Hold req, we, addr, wdata stable until gnt.
  - Drop req in the gnt cycle unless issuing a new access.
  - A req still high in DONE is re-arbitrated in the following IDLE.
- ram_addr / ram_wdata are 0 outside ACCESS. ram_we is only ever high in ACCESS.
- rdataX holds its value until the next completed load on that port. Stores never change rdataX.
- The losing requester's req is ignored, not queued; it wins at the latest on the next arbitration when RR is on.
- gnt0 and gnt1 are never high together; likewise done0/done1.
- DEPTH = 2^ADDR_W means no address is out of range; err never asserts.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register updates on each grant.
  - On simultaneous requests, the port other than last_grant wins.
  - Reset value makes port 0 win the first tie.
- Undefined: fixed priority, port 0 always wins ties. No last_grant register.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then port 0 load from addr 0x03; RAM preloaded 0x03 = 0x0004:
  - gnt0 in cycle 1, done0 in cycle 2, rdata0 = 0x0004.
  - ram_we stays 0 throughout.
- Port 1 store 0xBEEF to 0x20, then port 0 load from 0x20:
  - ram_we = 1 for exactly 1 cycle with ram_addr = 0x20.
  - Later rdata0 = 0xBEEF; rdata1 unchanged.
- req0 and req1 asserted together and held for 4 accesses:
  - With DMEM_ARB_RR_EN: grants alternate 0, 1, 0, 1.
  - Without it: grants 0, 0, 0, 0 while req0 is held.
- DEPTH = 200, port 0 store to 0xF0, then load from 0xF0:
  - ram_we never high.
  - err0 pulses with done0 both times.
  - rdata0 = 0x0000.
- rst_n driven low during ACCESS of a port 1 store:
  - The next cycle shows busy = 0, ram_we = 0, no done1 pulse, rdata0/1 = 0.
- Back-to-back port 0 loads with req0 held high:
  - done0 every 3 cycles.
  - gnt0/done0 never overlap with gnt1/done1.
